// File: rtl/parking_gate_ctrl.sv
// Multi-lane parking barrier controller: per-gate IDLE/OPEN FSMs with capacity reservation.
// Optional per-gate stuck alarm enabled by defining GATE_TIMEOUT_EN.
module parking_gate_ctrl #(
  parameter int CAPACITY       = 10,
  parameter int N_ENTRY        = 2,
  parameter int N_EXIT         = 2,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = $clog2(CAPACITY + 1)
) (
  input  logic                        clk_2,
  input  logic                        reset,
  input  logic [N_ENTRY-1:0]          entry_req,
  input  logic [N_EXIT-1:0]           exit_req,
  input  logic                        lot_closed,
  output logic [N_ENTRY-1:0]          entry_open,
  output logic [N_EXIT-1:0]           exit_open,
  output logic [CNT_W-1:0]            occupancy,
  output logic                        full,
  output logic                        empty,
  output logic [N_ENTRY+N_EXIT-1:0]   stuck
);

  localparam int SUM_W = CNT_W + 3;

  typedef enum logic {IDLE = 1'b0, OPEN = 1'b1} gate_state_t;

  gate_state_t entry_state_r [N_ENTRY];
  gate_state_t entry_state_s [N_ENTRY];
  gate_state_t exit_state_r  [N_EXIT];
  gate_state_t exit_state_s  [N_EXIT];

  logic [CNT_W-1:0]   occupancy_r;
  logic [SUM_W-1:0]   occ_ext_s;
  logic [SUM_W-1:0]   res_in_s;
  logic [SUM_W-1:0]   res_out_s;
  logic [SUM_W-1:0]   entry_commits_s;
  logic [SUM_W-1:0]   exit_commits_s;
  logic [SUM_W-1:0]   occ_next_s;
  logic               entry_room_s;
  logic               exit_room_s;
  logic [N_ENTRY-1:0] entry_grant_s;
  logic [N_EXIT-1:0]  exit_grant_s;
  logic               entry_taken_s;
  logic               exit_taken_s;

  // Reservations, commit counts and room checks, all from registered state
  always_comb begin
    res_in_s        = {SUM_W{1'b0}};
    res_out_s       = {SUM_W{1'b0}};
    entry_commits_s = {SUM_W{1'b0}};
    exit_commits_s  = {SUM_W{1'b0}};
    for (int i = 0; i < N_ENTRY; i++) begin
      res_in_s        = res_in_s + SUM_W'(entry_state_r[i] == OPEN);
      entry_commits_s = entry_commits_s + SUM_W'((entry_state_r[i] == OPEN) && !entry_req[i]);
    end
    for (int j = 0; j < N_EXIT; j++) begin
      res_out_s      = res_out_s + SUM_W'(exit_state_r[j] == OPEN);
      exit_commits_s = exit_commits_s + SUM_W'((exit_state_r[j] == OPEN) && !exit_req[j]);
    end
    occ_ext_s    = SUM_W'(occupancy_r);
    entry_room_s = ((occ_ext_s + res_in_s) < SUM_W'(CAPACITY)) && !lot_closed;
    exit_room_s  = occ_ext_s > res_out_s;
    occ_next_s   = occ_ext_s + entry_commits_s - exit_commits_s;
  end

  // Lowest-index idle requester wins, one grant per direction per cycle
  always_comb begin
    entry_grant_s = {N_ENTRY{1'b0}};
    exit_grant_s  = {N_EXIT{1'b0}};
    entry_taken_s = 1'b0;
    exit_taken_s  = 1'b0;
    for (int i = 0; i < N_ENTRY; i++) begin
      if (!entry_taken_s && entry_room_s && entry_req[i] && (entry_state_r[i] == IDLE)) begin
        entry_grant_s[i] = 1'b1;
        entry_taken_s    = 1'b1;
      end else begin
        entry_grant_s[i] = 1'b0;
      end
    end
    for (int j = 0; j < N_EXIT; j++) begin
      if (!exit_taken_s && exit_room_s && exit_req[j] && (exit_state_r[j] == IDLE)) begin
        exit_grant_s[j] = 1'b1;
        exit_taken_s    = 1'b1;
      end else begin
        exit_grant_s[j] = 1'b0;
      end
    end
  end

  // Per-gate next-state logic
  always_comb begin
    for (int i = 0; i < N_ENTRY; i++) begin
      entry_state_s[i] = entry_state_r[i];
      case (entry_state_r[i])
        IDLE:    entry_state_s[i] = entry_grant_s[i] ? OPEN : IDLE;
        OPEN:    entry_state_s[i] = entry_req[i] ? OPEN : IDLE;
        default: entry_state_s[i] = IDLE;
      endcase
    end
    for (int j = 0; j < N_EXIT; j++) begin
      exit_state_s[j] = exit_state_r[j];
      case (exit_state_r[j])
        IDLE:    exit_state_s[j] = exit_grant_s[j] ? OPEN : IDLE;
        OPEN:    exit_state_s[j] = exit_req[j] ? OPEN : IDLE;
        default: exit_state_s[j] = IDLE;
      endcase
    end
  end

  // Gate state and committed occupancy registers
  always_ff @(posedge clk_2) begin
    if (reset) begin
      for (int i = 0; i < N_ENTRY; i++) entry_state_r[i] <= IDLE;
      for (int j = 0; j < N_EXIT; j++)  exit_state_r[j]  <= IDLE;
      occupancy_r <= {CNT_W{1'b0}};
    end else begin
      for (int i = 0; i < N_ENTRY; i++) entry_state_r[i] <= entry_state_s[i];
      for (int j = 0; j < N_EXIT; j++)  exit_state_r[j]  <= exit_state_s[j];
      occupancy_r <= CNT_W'(occ_next_s);
    end
  end

  // Output decode straight from registered state
  always_comb begin
    for (int i = 0; i < N_ENTRY; i++) entry_open[i] = (entry_state_r[i] == OPEN);
    for (int j = 0; j < N_EXIT; j++)  exit_open[j]  = (exit_state_r[j] == OPEN);
    occupancy = occupancy_r;
    full      = (occupancy_r == CNT_W'(CAPACITY));
    empty     = (occupancy_r == {CNT_W{1'b0}});
  end

`ifdef GATE_TIMEOUT_EN
  localparam int N_GATES = N_ENTRY + N_EXIT;
  localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0]    to_cnt_r [N_GATES];
  logic [TO_W-1:0]    to_cnt_s [N_GATES];
  logic [N_GATES-1:0] gate_open_s;
  logic [N_GATES-1:0] gate_open_next_s;
  logic [N_GATES-1:0] stuck_r;
  logic [N_GATES-1:0] stuck_s;

  // Saturating open-time counters; stuck raised once the count hits the limit
  always_comb begin
    for (int i = 0; i < N_ENTRY; i++) begin
      gate_open_s[i]      = (entry_state_r[i] == OPEN);
      gate_open_next_s[i] = (entry_state_s[i] == OPEN);
    end
    for (int j = 0; j < N_EXIT; j++) begin
      gate_open_s[N_ENTRY+j]      = (exit_state_r[j] == OPEN);
      gate_open_next_s[N_ENTRY+j] = (exit_state_s[j] == OPEN);
    end
    for (int g = 0; g < N_GATES; g++) begin
      if (!gate_open_s[g]) begin
        to_cnt_s[g] = {TO_W{1'b0}};
      end else if (to_cnt_r[g] == TO_W'(TIMEOUT_CYCLES)) begin
        to_cnt_s[g] = to_cnt_r[g];
      end else begin
        to_cnt_s[g] = to_cnt_r[g] + TO_W'(1'b1);
      end
      stuck_s[g] = gate_open_next_s[g] && (to_cnt_s[g] == TO_W'(TIMEOUT_CYCLES));
    end
  end

  // Timeout counter and alarm registers
  always_ff @(posedge clk_2) begin
    if (reset) begin
      for (int g = 0; g < N_GATES; g++) to_cnt_r[g] <= {TO_W{1'b0}};
      stuck_r <= {N_GATES{1'b0}};
    end else begin
      for (int g = 0; g < N_GATES; g++) to_cnt_r[g] <= to_cnt_s[g];
      stuck_r <= stuck_s;
    end
  end

  assign stuck = stuck_r;
`else
  assign stuck = {(N_ENTRY + N_EXIT){1'b0}};
`endif

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Table-driven scoreboard bench for parking_gate_ctrl with CAPACITY=3, two lanes each way.
module tb_parking_gate_ctrl;

  localparam int CAP = 3;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] entry_req = 2'b00;
  logic [1:0] exit_req = 2'b00;
  logic       lot_closed = 1'b0;
  logic [1:0] entry_open;
  logic [1:0] exit_open;
  logic [1:0] occupancy;
  logic       full;
  logic       empty;
  logic [3:0] stuck;

  parking_gate_ctrl #(
    .CAPACITY(CAP), .N_ENTRY(2), .N_EXIT(2), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_2(clk_2), .reset(reset), .entry_req(entry_req), .exit_req(exit_req),
    .lot_closed(lot_closed), .entry_open(entry_open), .exit_open(exit_open),
    .occupancy(occupancy), .full(full), .empty(empty), .stuck(stuck)
  );

  always #5 clk_2 = ~clk_2;

  typedef struct {
    logic [1:0] er;
    logic [1:0] xr;
    logic       lc;
    logic       rst;
    logic [1:0] eo;
    logic [1:0] xo;
    logic [7:0] occ;
    logic [3:0] stk;
  } vec_t;

  vec_t tbl [40];
  vec_t exp_q [$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input logic [1:0] er, input logic [1:0] xr, input logic lc,
                              input logic rst, input logic [1:0] eo, input logic [1:0] xo,
                              input int occ);
    vec_t v;
    v.er = er; v.xr = xr; v.lc = lc; v.rst = rst;
    v.eo = eo; v.xo = xo; v.occ = 8'(occ); v.stk = 4'b0000;
    return v;
  endfunction

  task automatic chk(input string name, input int step, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step, got, want);
    end
  endtask

  task automatic apply(input vec_t v, input int step);
    vec_t e;
    @(negedge clk_2);
    entry_req  = v.er;
    exit_req   = v.xr;
    lot_closed = v.lc;
    reset      = v.rst;
    exp_q.push_back(v);
    @(posedge clk_2);
    #1;
    e = exp_q.pop_front();
    chk("entry_open", step, {6'b0, entry_open}, {6'b0, e.eo});
    chk("exit_open",  step, {6'b0, exit_open},  {6'b0, e.xo});
    chk("occupancy",  step, {6'b0, occupancy},  e.occ);
    chk("full",       step, {7'b0, full},       {7'b0, (e.occ == 8'(CAP))});
    chk("empty",      step, {7'b0, empty},      {7'b0, (e.occ == 8'd0)});
    chk("stuck",      step, {4'b0, stuck},      {4'b0, e.stk});
  endtask

  initial begin
    vec_t v;
    // reset, then fill lane 0 to capacity and get denied
    tbl[0]  = mk(2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 2'b00, 0);
    tbl[1]  = mk(2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 0);
    tbl[2]  = mk(2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 0);
    tbl[3]  = mk(2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1);
    tbl[4]  = mk(2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 1);
    tbl[5]  = mk(2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 1);
    tbl[6]  = mk(2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2);
    tbl[7]  = mk(2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 2);
    tbl[8]  = mk(2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 2);
    tbl[9]  = mk(2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 3);
    tbl[10] = mk(2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 3);
    tbl[11] = mk(2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 3);
    tbl[12] = mk(2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 3);
    tbl[13] = mk(2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 3);
    // one exit to reach 2, then the reservation race
    tbl[14] = mk(2'b00, 2'b01, 1'b0, 1'b0, 2'b00, 2'b01, 3);
    tbl[15] = mk(2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2);
    tbl[16] = mk(2'b11, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 2);
    tbl[17] = mk(2'b11, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 2);
    tbl[18] = mk(2'b10, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 3);
    tbl[19] = mk(2'b10, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 3);
    tbl[20] = mk(2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 3);
    // two exits staggered by arbitration, committing together
    tbl[21] = mk(2'b00, 2'b11, 1'b0, 1'b0, 2'b00, 2'b01, 3);
    tbl[22] = mk(2'b00, 2'b11, 1'b0, 1'b0, 2'b00, 2'b11, 3);
    tbl[23] = mk(2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1);
    // simultaneous entry and exit commit at occupancy 1
    tbl[24] = mk(2'b10, 2'b01, 1'b0, 1'b0, 2'b10, 2'b01, 1);
    tbl[25] = mk(2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1);
    // empty guard on exit lane 1
    tbl[26] = mk(2'b00, 2'b01, 1'b0, 1'b0, 2'b00, 2'b01, 1);
    tbl[27] = mk(2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 0);
    tbl[28] = mk(2'b00, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00, 0);
    tbl[29] = mk(2'b01, 2'b10, 1'b0, 1'b0, 2'b01, 2'b00, 0);
    tbl[30] = mk(2'b00, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00, 1);
    tbl[31] = mk(2'b00, 2'b10, 1'b0, 1'b0, 2'b00, 2'b10, 1);
    tbl[32] = mk(2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 0);
    // lot closed, then reset with gates open
    tbl[33] = mk(2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 0);
    tbl[34] = mk(2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1);
    tbl[35] = mk(2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1);
    tbl[36] = mk(2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1);
    tbl[37] = mk(2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 1);
    tbl[38] = mk(2'b01, 2'b01, 1'b0, 1'b1, 2'b00, 2'b00, 0);
    tbl[39] = mk(2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 0);

    for (int i = 0; i < 40; i++) apply(tbl[i], i);

    // long hold on entry lane 0: alarm from the 5th open cycle when enabled
    for (int k = 1; k <= 8; k++) begin
      v = mk(2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 0);
`ifdef GATE_TIMEOUT_EN
      v.stk = (k >= 5) ? 4'b0001 : 4'b0000;
`else
      v.stk = 4'b0000;
`endif
      apply(v, 100 + k);
    end
    v = mk(2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1);
    apply(v, 109);
    v = mk(2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1);
    apply(v, 110);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
